group_scheduler: RTL and testbench

Sequences the opx multiplexer by selecting which instruction group owns the datapath in each cycle. It inserts the fetch phase between instructions and arbitrates at instruction boundaries between the next instruction, interrupt entry and debug takeover. It sits between the instruction decoder and the opx multiplexer, driving its `INSTRUCTION_GROUP` select. It also supplies the interrupt and debug handshakes.

---
 rtl/group_scheduler.sv | 174 +++++++++++++++++
 tb/tb_group_scheduler.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/group_scheduler.sv
// Instruction-group sequencer for the opx multiplexer: FETCH/EXEC phases plus interrupt entry and debug halt.
// Optional EXEC watchdog compiled in with GROUP_SCHED_WATCHDOG_EN.
module group_scheduler #(
    parameter int unsigned INT_CYCLES      = 2,
    parameter int unsigned MAX_EXEC_CYCLES = 15
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic [2:0] FETCH_GROUP,
    input  logic       INSTR_VALID,
    input  logic       INSTR_DONE,
    input  logic       INT_EN,
    input  logic       INT_REQ,
    input  logic       DEBUG_REQ,
    input  logic       DEBUG_STEP,
    output logic [2:0] INSTRUCTION_GROUP,
    output logic       INT_ACK,
    output logic       DEBUG_ACK,
    output logic       HALTED,
    output logic       FAULT
);

    localparam logic [2:0] GROUPX_SYS = 3'd0;
    localparam logic [2:0] GROUPX_ALU = 3'd1;
    localparam logic [2:0] GROUPX_JMP = 3'd2;
    localparam logic [2:0] GROUPX_LDS = 3'd3;
    localparam logic [2:0] GROUPX_DBG = 3'd4;

    if (INT_CYCLES < 1 || INT_CYCLES > 15) begin : g_bad_int_cycles
        $error("group_scheduler: INT_CYCLES must be 1..15");
    end
    if (MAX_EXEC_CYCLES < 1 || MAX_EXEC_CYCLES > 255) begin : g_bad_max_exec
        $error("group_scheduler: MAX_EXEC_CYCLES must be 1..255");
    end

    typedef enum logic [1:0] {
        ST_FETCH    = 2'd0,
        ST_EXEC     = 2'd1,
        ST_INT      = 2'd2,
        ST_DBG_HALT = 2'd3
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [2:0] r_group;
    logic [2:0] w_group_nxt;
    logic [2:0] w_fetch_map;
    logic       r_step;
    logic       w_step_nxt;
    logic [3:0] r_int_cnt;
    logic [3:0] w_int_cnt_nxt;
    logic       r_int_ack;
    logic       r_dbg_ack;
    logic       w_natural_done;
    logic       w_wd_expire;
    logic       w_done;

    // Handshakes are level based: INT_REQ is held by the requester until INT_ACK is seen,
    // DEBUG_REQ is held for as long as the halt is wanted and DEBUG_ACK/HALTED answer it.
    assign w_fetch_map    = (FETCH_GROUP < GROUPX_DBG) ? FETCH_GROUP : GROUPX_SYS;
    assign w_natural_done = INSTR_DONE || (r_group == GROUPX_SYS);
    assign w_done         = w_natural_done || w_wd_expire;

`ifdef GROUP_SCHED_WATCHDOG_EN
    logic [7:0] r_wd_cnt;
    logic       r_fault;

    assign w_wd_expire = (r_state == ST_EXEC) && !w_natural_done
                         && (r_wd_cnt == 8'(MAX_EXEC_CYCLES - 1));

    // Only FETCH leads into EXEC, so clearing while in FETCH is the entry clear.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_wd_cnt <= 8'd0;
            r_fault  <= 1'b0;
        end else begin
            if (r_state == ST_FETCH) begin
                r_wd_cnt <= 8'd0;
            end else if (r_state == ST_EXEC) begin
                r_wd_cnt <= r_wd_cnt + 8'd1;
            end
            if (w_wd_expire) begin
                r_fault <= 1'b1;
            end
        end
    end

    assign FAULT = r_fault;
`else
    assign w_wd_expire = 1'b0;
    assign FAULT       = 1'b0;
`endif

    always_comb begin
        w_state_nxt   = r_state;
        w_group_nxt   = r_group;
        w_step_nxt    = r_step;
        w_int_cnt_nxt = r_int_cnt;
        case (r_state)
            ST_FETCH: begin
                w_group_nxt = GROUPX_SYS;
                if (INSTR_VALID) begin
                    w_state_nxt = ST_EXEC;
                    w_group_nxt = w_fetch_map;
                end
            end
            ST_EXEC: begin
                if (w_done) begin
                    if (r_step || DEBUG_REQ) begin
                        w_state_nxt = ST_DBG_HALT;
                        w_group_nxt = GROUPX_DBG;
                        w_step_nxt  = 1'b0;
                    end else if (INT_REQ && INT_EN) begin
                        w_state_nxt   = ST_INT;
                        w_group_nxt   = GROUPX_SYS;
                        w_int_cnt_nxt = 4'd0;
                    end else begin
                        w_state_nxt = ST_FETCH;
                        w_group_nxt = GROUPX_SYS;
                    end
                end
            end
            ST_INT: begin
                w_group_nxt = GROUPX_SYS;
                if (r_int_cnt == 4'(INT_CYCLES - 1)) begin
                    w_state_nxt   = ST_FETCH;
                    w_int_cnt_nxt = 4'd0;
                end else begin
                    w_int_cnt_nxt = r_int_cnt + 4'd1;
                end
            end
            ST_DBG_HALT: begin
                w_group_nxt = GROUPX_DBG;
                // A step wins over a simultaneous resume so the core re-halts after one instruction.
                if (DEBUG_STEP) begin
                    w_step_nxt  = 1'b1;
                    w_state_nxt = ST_FETCH;
                    w_group_nxt = GROUPX_SYS;
                end else if (!DEBUG_REQ) begin
                    w_state_nxt = ST_FETCH;
                    w_group_nxt = GROUPX_SYS;
                end
            end
            default: begin
                w_state_nxt = ST_FETCH;
                w_group_nxt = GROUPX_SYS;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state   <= ST_FETCH;
            r_group   <= GROUPX_SYS;
            r_step    <= 1'b0;
            r_int_cnt <= 4'd0;
            r_int_ack <= 1'b0;
            r_dbg_ack <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_group   <= w_group_nxt;
            r_step    <= w_step_nxt;
            r_int_cnt <= w_int_cnt_nxt;
            r_int_ack <= (w_state_nxt == ST_INT);
            r_dbg_ack <= (w_state_nxt == ST_DBG_HALT);
        end
    end

    assign INSTRUCTION_GROUP = r_group;
    assign INT_ACK           = r_int_ack;
    assign DEBUG_ACK         = r_dbg_ack;
    assign HALTED            = r_dbg_ack;

endmodule

// File: tb/tb_group_scheduler.sv
// Self-checking bench for group_scheduler: directed test-plan steps followed by random traffic,
// checked cycle by cycle against a transaction-level model (watchdog checks follow GROUP_SCHED_WATCHDOG_EN).
module tb_group_scheduler;

    localparam int unsigned INT_CYC = 2;
    localparam int unsigned MAX_EXC = 15;

    localparam logic [2:0] G_SYS = 3'd0;
    localparam logic [2:0] G_ALU = 3'd1;
    localparam logic [2:0] G_JMP = 3'd2;
    localparam logic [2:0] G_LDS = 3'd3;
    localparam logic [2:0] G_DBG = 3'd4;

    logic       CLK = 1'b0;
    logic       RESET_N;
    logic [2:0] FETCH_GROUP;
    logic       INSTR_VALID;
    logic       INSTR_DONE;
    logic       INT_EN;
    logic       INT_REQ;
    logic       DEBUG_REQ;
    logic       DEBUG_STEP;
    logic [2:0] INSTRUCTION_GROUP;
    logic       INT_ACK;
    logic       DEBUG_ACK;
    logic       HALTED;
    logic       FAULT;

    group_scheduler #(
        .INT_CYCLES     (INT_CYC),
        .MAX_EXEC_CYCLES(MAX_EXC)
    ) dut (
        .CLK              (CLK),
        .RESET_N          (RESET_N),
        .FETCH_GROUP      (FETCH_GROUP),
        .INSTR_VALID      (INSTR_VALID),
        .INSTR_DONE       (INSTR_DONE),
        .INT_EN           (INT_EN),
        .INT_REQ          (INT_REQ),
        .DEBUG_REQ        (DEBUG_REQ),
        .DEBUG_STEP       (DEBUG_STEP),
        .INSTRUCTION_GROUP(INSTRUCTION_GROUP),
        .INT_ACK          (INT_ACK),
        .DEBUG_ACK        (DEBUG_ACK),
        .HALTED           (HALTED),
        .FAULT            (FAULT)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: what the core is doing, not how the scheduler encodes it.
    bit         m_halted;
    int         m_int_left;
    bit         m_busy;
    logic [2:0] m_cur;
    bit         m_step_pend;
    bit         m_fault;
`ifdef GROUP_SCHED_WATCHDOG_EN
    int         m_exec_cycles;
`endif

    task automatic model_reset();
        m_halted    = 0;
        m_int_left  = 0;
        m_busy      = 0;
        m_cur       = G_SYS;
        m_step_pend = 0;
        m_fault     = 0;
`ifdef GROUP_SCHED_WATCHDOG_EN
        m_exec_cycles = 0;
`endif
    endtask

    task automatic model_update();
        bit finished;
        if (m_halted) begin
            if (DEBUG_STEP) begin
                m_step_pend = 1;
                m_halted    = 0;
            end else if (!DEBUG_REQ) begin
                m_halted = 0;
            end
        end else if (m_int_left > 0) begin
            m_int_left--;
        end else if (m_busy) begin
            finished = (m_cur == G_SYS) || INSTR_DONE;
`ifdef GROUP_SCHED_WATCHDOG_EN
            m_exec_cycles++;
            if (!finished && m_exec_cycles == int'(MAX_EXC)) begin
                m_fault  = 1;
                finished = 1;
            end
`endif
            if (finished) begin
                m_busy = 0;
                if (m_step_pend || DEBUG_REQ) begin
                    m_halted    = 1;
                    m_step_pend = 0;
                end else if (INT_REQ && INT_EN) begin
                    m_int_left = INT_CYC;
                end
            end
        end else if (INSTR_VALID) begin
            m_busy = 1;
            m_cur  = (FETCH_GROUP <= G_LDS) ? FETCH_GROUP : G_SYS;
`ifdef GROUP_SCHED_WATCHDOG_EN
            m_exec_cycles = 0;
`endif
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic check(input string tag);
        logic [2:0] eg;
        eg = m_halted ? G_DBG : (m_int_left > 0) ? G_SYS : m_busy ? m_cur : G_SYS;
        chk($sformatf("%s.group", tag), {5'd0, INSTRUCTION_GROUP}, {5'd0, eg});
        chk($sformatf("%s.int_ack", tag), {7'd0, INT_ACK}, {7'd0, m_int_left > 0});
        chk($sformatf("%s.debug_ack", tag), {7'd0, DEBUG_ACK}, {7'd0, m_halted});
        chk($sformatf("%s.halted", tag), {7'd0, HALTED}, {7'd0, m_halted});
        chk($sformatf("%s.fault", tag), {7'd0, FAULT}, {7'd0, m_fault});
    endtask

    task automatic drive(input logic v, input logic [2:0] g, input logic d, input logic ie,
                         input logic ir, input logic dr, input logic ds);
        INSTR_VALID = v;
        FETCH_GROUP = g;
        INSTR_DONE  = d;
        INT_EN      = ie;
        INT_REQ     = ir;
        DEBUG_REQ   = dr;
        DEBUG_STEP  = ds;
    endtask

    task automatic tick(input string tag);
        @(posedge CLK);
        model_update();
        #1;
        check(tag);
    endtask

    task automatic step(input logic v, input logic [2:0] g, input logic d, input logic ie,
                        input logic ir, input logic dr, input logic ds, input string tag);
        drive(v, g, d, ie, ir, dr, ds);
        tick(tag);
    endtask

    task automatic async_reset(input string tag);
        #2;
        RESET_N = 1'b0;
        model_reset();
        #1;
        check(tag);
        @(negedge CLK);
        RESET_N = 1'b1;
    endtask

    initial begin
        int acks;
        RESET_N = 1'b0;
        drive(0, G_SYS, 0, 0, 0, 0, 0);
        model_reset();
        #12;
        check("reset");
        @(negedge CLK);
        RESET_N = 1'b1;

        // Plain ALU instruction, three EXEC cycles
        step(0, G_SYS, 0, 0, 0, 0, 0, "idle");
        step(1, G_ALU, 0, 0, 0, 0, 0, "alu_latch");
        step(0, G_SYS, 0, 0, 0, 0, 0, "alu_x1");
        step(0, G_SYS, 0, 0, 0, 0, 0, "alu_x2");
        step(0, G_SYS, 1, 0, 0, 0, 0, "alu_done");

        // JMP with interrupt taken at the boundary
        step(1, G_JMP, 0, 1, 1, 0, 0, "jmp_latch");
        step(0, G_SYS, 0, 1, 1, 0, 0, "jmp_x1");
        step(0, G_SYS, 1, 1, 1, 0, 0, "jmp_int");
        acks = int'(INT_ACK);
        for (int i = 0; i < 3; i++) begin
            step(0, G_SYS, 0, 1, 0, 0, 0, "int_body");
            acks += int'(INT_ACK);
        end
        chk("int_ack_len", 8'(acks), 8'(INT_CYC));

        // Same with interrupts disabled
        step(1, G_JMP, 0, 0, 1, 0, 0, "jmp2_latch");
        step(0, G_SYS, 1, 0, 1, 0, 0, "jmp2_noint");
        step(0, G_SYS, 0, 0, 0, 0, 0, "jmp2_fetch");

        // Debug and interrupt together: debug wins, interrupt waits
        step(1, G_ALU, 0, 1, 1, 1, 0, "dbgint_latch");
        step(0, G_SYS, 1, 1, 1, 1, 0, "dbgint_halt");
        step(0, G_SYS, 0, 1, 1, 1, 0, "halt_hold1");
        step(0, G_SYS, 0, 1, 1, 1, 0, "halt_hold2");
        step(0, G_SYS, 0, 1, 1, 0, 0, "resume");
        step(1, G_ALU, 0, 1, 1, 0, 0, "post_latch");
        step(0, G_SYS, 1, 1, 1, 0, 0, "post_int");
        step(0, G_SYS, 0, 1, 0, 0, 0, "post_int_b");
        step(0, G_SYS, 0, 1, 0, 0, 0, "post_int_c");

        // Single step with LDS while debug is held
        step(1, G_ALU, 0, 0, 0, 1, 0, "ss_latch");
        step(0, G_SYS, 1, 0, 0, 1, 0, "ss_halt");
        step(0, G_SYS, 0, 0, 0, 1, 1, "ss_pulse");
        step(1, G_LDS, 0, 0, 0, 1, 0, "ss_lds");
        step(0, G_SYS, 1, 0, 0, 1, 0, "ss_rehalt");
        chk("ss_rehalt_halted", {7'd0, HALTED}, 8'd1);
        // Step pulse with DEBUG_REQ dropped on the same cycle
        step(0, G_SYS, 0, 0, 0, 0, 1, "ss2_pulse");
        step(1, G_LDS, 0, 1, 1, 0, 0, "ss2_lds");
        step(0, G_SYS, 1, 1, 1, 0, 0, "ss2_rehalt");
        chk("ss2_rehalt_halted", {7'd0, HALTED}, 8'd1);
        step(0, G_SYS, 0, 0, 0, 0, 0, "ss2_resume");

        // Undefined code and DBG code both run as a single SYS cycle
        step(1, 3'd7, 0, 0, 0, 0, 0, "code7_latch");
        step(0, G_SYS, 0, 0, 0, 0, 0, "code7_end");
        step(1, G_DBG, 0, 0, 0, 0, 0, "code4_latch");
        step(0, G_SYS, 0, 0, 0, 0, 0, "code4_end");

        // Reset in the middle of interrupt entry
        step(1, G_ALU, 0, 1, 1, 0, 0, "rst_latch");
        step(0, G_SYS, 1, 1, 1, 0, 0, "rst_int");
        async_reset("rst_mid_int");
        step(0, G_SYS, 0, 0, 0, 0, 0, "rst_after");

`ifdef GROUP_SCHED_WATCHDOG_EN
        step(1, G_ALU, 0, 0, 0, 0, 0, "wd_latch");
        for (int i = 0; i < 16; i++) step(0, G_SYS, 0, 0, 0, 0, 0, "wd_wait");
        chk("wd_fault_set", {7'd0, FAULT}, 8'd1);
        step(1, G_ALU, 0, 0, 0, 0, 0, "wd2_latch");
        step(0, G_SYS, 0, 0, 0, 0, 0, "wd2_x1");
        async_reset("wd_rst_mid_exec");
`endif

        // Random traffic
        drive(0, G_SYS, 0, 0, 0, 0, 0);
        for (int i = 0; i < 800; i++) begin
            logic ireq;
            logic dreq;
            ireq = INT_REQ ? !INT_ACK : ($urandom_range(0, 5) == 0);
            dreq = ($urandom_range(0, 11) == 0) ? !DEBUG_REQ : DEBUG_REQ;
            step($urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)), $urandom_range(0, 2) == 0,
                 $urandom_range(0, 3) != 0, ireq, dreq, $urandom_range(0, 5) == 0, "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
